// File: rtl/cla_result_checker_if.sv
// Adder-side observation bus for cla_result_checker: issued operands, adder result, check results.
// No backpressure; the checker samples every cycle and never stalls the source.
interface cla_result_checker_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] Z;
  logic             Cout;
  logic             chk_valid;
  logic             mismatch;
  logic             err_sticky;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [WIDTH:0]   first_fail_exp;
  logic [WIDTH:0]   first_fail_got;
  logic [1:0]       state;

  modport master (
    output clear, in_valid, A, B, Cin, Z, Cout,
    input  chk_valid, mismatch, err_sticky, pass_cnt, fail_cnt,
           first_fail_exp, first_fail_got, state
  );

  modport slave (
    input  clear, in_valid, A, B, Cin, Z, Cout,
    output chk_valid, mismatch, err_sticky, pass_cnt, fail_cnt,
           first_fail_exp, first_fail_got, state
  );
endinterface

// File: rtl/cla_result_checker.sv
// Golden-model checker for the CLA adder; results appear LATENCY+1 cycles after issue, no backpressure.
// Optional CLA_CHK_HALT_EN: once FAILED, stop comparing/counting while the pipeline keeps draining.
module cla_result_checker #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 0,
  parameter int CNT_W   = 16
) (
  input logic                 clk,
  input logic                 reset,
  cla_result_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    FAILED = 2'b10
  } state_t;

  state_t           st;
  logic             chk_valid_q;
  logic             mismatch_q;
  logic             err_sticky_q;
  logic [CNT_W-1:0] pass_cnt_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic [WIDTH:0]   ff_exp_q;
  logic [WIDTH:0]   ff_got_q;

  logic [WIDTH:0] exp_now;
  logic [WIDTH:0] got_now;
  logic           cmp_vld;
  logic [WIDTH:0] cmp_exp;
  logic           pipe_busy;
  logic           cmp_mis;
  logic           halted;
  logic           count_en;
  logic           fail_ev;

  assign exp_now = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.Cin};
  assign got_now = {bus.Cout, bus.Z};

  generate
    if (LATENCY == 0) begin : g_nopipe
      assign cmp_vld   = bus.in_valid;
      assign cmp_exp   = exp_now;
      assign pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [LATENCY-1:0] pv;
      logic [WIDTH:0]     pe [LATENCY];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pv <= '0;
          for (int i = 0; i < LATENCY; i++) pe[i] <= '0;
        end else begin
          pv[0] <= bus.in_valid;
          pe[0] <= exp_now;
          for (int i = 1; i < LATENCY; i++) begin
            pv[i] <= pv[i-1];
            pe[i] <= pe[i-1];
          end
        end
      end

      // The last stage is the one being compared this cycle; it still counts as in flight.
      assign cmp_vld   = pv[LATENCY-1];
      assign cmp_exp   = pe[LATENCY-1];
      assign pipe_busy = |pv;
    end
  endgenerate

`ifdef CLA_CHK_HALT_EN
  assign halted = (st == FAILED);
`else
  assign halted = 1'b0;
`endif

  assign cmp_mis  = (cmp_exp != got_now);
  assign count_en = cmp_vld & ~halted & ~bus.clear;
  assign fail_ev  = count_en & cmp_mis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= IDLE;
      chk_valid_q  <= 1'b0;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      ff_exp_q     <= '0;
      ff_got_q     <= '0;
    end else if (bus.clear) begin
      // A compare landing on a clear cycle is dropped; the pipeline itself keeps flowing.
      st           <= IDLE;
      chk_valid_q  <= 1'b0;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      ff_exp_q     <= '0;
      ff_got_q     <= '0;
    end else begin
      chk_valid_q <= count_en;
      mismatch_q  <= fail_ev;
      if (count_en && !cmp_mis && (pass_cnt_q != '1)) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
      if (fail_ev && (fail_cnt_q != '1)) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
      if (fail_ev && !err_sticky_q) begin
        ff_exp_q <= cmp_exp;
        ff_got_q <= got_now;
      end
      if (fail_ev) err_sticky_q <= 1'b1;

      case (st)
        IDLE: begin
          if (fail_ev) st <= FAILED;
          else if (bus.in_valid) st <= ACTIVE;
        end
        ACTIVE: begin
          if (fail_ev) st <= FAILED;
          else if (!bus.in_valid && !pipe_busy) st <= IDLE;
        end
        FAILED:  st <= FAILED;
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.chk_valid      = chk_valid_q;
  assign bus.mismatch       = mismatch_q;
  assign bus.err_sticky     = err_sticky_q;
  assign bus.pass_cnt       = pass_cnt_q;
  assign bus.fail_cnt       = fail_cnt_q;
  assign bus.first_fail_exp = ff_exp_q;
  assign bus.first_fail_got = ff_got_q;
  assign bus.state          = st;

endmodule

// File: tb/tb_cla_result_checker.sv
// Bench for cla_result_checker: LATENCY=0/CNT_W=16 and LATENCY=3/CNT_W=4 instances on shared stimulus.
// A transaction-level model (queue of issued items with due cycles) predicts every output each cycle.
module tb_cla_result_checker;

`ifdef CLA_CHK_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        iv, clr, cin_v, bad0, bad3;
  logic [15:0] a_v, b_v;
  int          cyc;
  int          n_cmp;
  int          n_bad;
  logic [16:0] hist[$];

  typedef struct {
    int          d;
    int          due;
    logic [16:0] ex;
    logic [16:0] gt;
  } item_t;
  item_t q[$];

  int          m_pass[2];
  int          m_fail[2];
  bit          m_sticky[2];
  logic [16:0] m_fexp[2];
  logic [16:0] m_fgot[2];
  int          m_state[2];
  bit          m_cv[2];
  bit          m_mis[2];

  cla_result_checker_if #(.WIDTH(16), .CNT_W(16)) i0 ();
  cla_result_checker_if #(.WIDTH(16), .CNT_W(4))  i3 ();

  cla_result_checker #(.WIDTH(16), .LATENCY(0), .CNT_W(16)) dut0 (
    .clk  (clk),
    .reset(rst),
    .bus  (i0.slave)
  );

  cla_result_checker #(.WIDTH(16), .LATENCY(3), .CNT_W(4)) dut3 (
    .clk  (clk),
    .reset(rst),
    .bus  (i3.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int d = 0; d < 2; d++) begin
      m_pass[d] = 0; m_fail[d] = 0; m_sticky[d] = 1'b0;
      m_fexp[d] = '0; m_fgot[d] = '0; m_state[d] = 0;
      m_cv[d] = 1'b0; m_mis[d] = 1'b0;
    end
  endtask

  // One clock of behaviour for instance d: items compare at issue edge + lat.
  task automatic model_step(input int d, input int lat, input int cmax,
                            input logic [16:0] ex, input logic [16:0] gt);
    bit    busy;
    bit    have;
    bit    cv;
    bit    mis;
    int    idx;
    item_t it;
    busy = 1'b0; have = 1'b0; cv = 1'b0; mis = 1'b0; idx = -1;
    foreach (q[i]) if (q[i].d == d) busy = 1'b1;
    if (iv) q.push_back('{d, cyc + lat, ex, gt});
    foreach (q[i]) if (q[i].d == d && q[i].due == cyc) idx = i;
    if (idx >= 0) begin
      it = q[idx];
      have = 1'b1;
      q.delete(idx);
    end
    if (clr) begin
      m_pass[d] = 0; m_fail[d] = 0; m_sticky[d] = 1'b0;
      m_fexp[d] = '0; m_fgot[d] = '0; m_state[d] = 0;
    end else begin
      if (have && !(HALT && m_state[d] == 2)) begin
        cv  = 1'b1;
        mis = (it.ex != it.gt);
        if (!mis && m_pass[d] < cmax) m_pass[d]++;
        if (mis && m_fail[d] < cmax) m_fail[d]++;
        if (mis && !m_sticky[d]) begin
          m_fexp[d] = it.ex;
          m_fgot[d] = it.gt;
        end
        if (mis) m_sticky[d] = 1'b1;
      end
      if (cv && mis) m_state[d] = 2;
      else if (m_state[d] == 0 && iv) m_state[d] = 1;
      else if (m_state[d] == 1 && !busy && !iv) m_state[d] = 0;
    end
    m_cv[d]  = cv;
    m_mis[d] = mis;
  endtask

  task automatic check_all();
    chk("d0.chk_valid", 32'(i0.chk_valid), 32'(m_cv[0]));
    if (m_cv[0]) chk("d0.mismatch", 32'(i0.mismatch), 32'(m_mis[0]));
    chk("d0.pass_cnt", 32'(i0.pass_cnt), 32'(m_pass[0]));
    chk("d0.fail_cnt", 32'(i0.fail_cnt), 32'(m_fail[0]));
    chk("d0.err_sticky", 32'(i0.err_sticky), 32'(m_sticky[0]));
    chk("d0.state", 32'(i0.state), 32'(m_state[0]));
    chk("d0.first_fail_exp", 32'(i0.first_fail_exp), 32'(m_fexp[0]));
    chk("d0.first_fail_got", 32'(i0.first_fail_got), 32'(m_fgot[0]));
    chk("d3.chk_valid", 32'(i3.chk_valid), 32'(m_cv[1]));
    if (m_cv[1]) chk("d3.mismatch", 32'(i3.mismatch), 32'(m_mis[1]));
    chk("d3.pass_cnt", 32'(i3.pass_cnt), 32'(m_pass[1]));
    chk("d3.fail_cnt", 32'(i3.fail_cnt), 32'(m_fail[1]));
    chk("d3.err_sticky", 32'(i3.err_sticky), 32'(m_sticky[1]));
    chk("d3.state", 32'(i3.state), 32'(m_state[1]));
    chk("d3.first_fail_exp", 32'(i3.first_fail_exp), 32'(m_fexp[1]));
    chk("d3.first_fail_got", 32'(i3.first_fail_got), 32'(m_fgot[1]));
  endtask

  // Drives both instances for one cycle; the LATENCY=3 adder stand-in replays its result 3 cycles late.
  task automatic tick();
    logic [16:0] s, g0, g3, h;
    s  = {1'b0, a_v} + {1'b0, b_v} + {16'b0, cin_v};
    g0 = s ^ {16'b0, bad0};
    g3 = s ^ {16'b0, bad3};
    hist.push_back(iv ? g3 : 17'h0);
    h = (hist.size() >= 4) ? hist[hist.size() - 4] : 17'h0;
    i0.clear = clr; i0.in_valid = iv; i0.A = a_v; i0.B = b_v; i0.Cin = cin_v;
    i0.Z = g0[15:0]; i0.Cout = g0[16];
    i3.clear = clr; i3.in_valid = iv; i3.A = a_v; i3.B = b_v; i3.Cin = cin_v;
    i3.Z = h[15:0]; i3.Cout = h[16];
    @(posedge clk);
    #1;
    cyc++;
    if (rst) model_reset();
    else begin
      model_step(0, 0, 65535, s, g0);
      model_step(1, 3, 15, s, g3);
    end
    check_all();
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic e0, input logic e3);
    iv = 1'b1; a_v = a; b_v = b; cin_v = c; bad0 = e0; bad3 = e3;
    tick();
    iv = 1'b0; bad0 = 1'b0; bad3 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst = 1'b1; iv = 1'b0; clr = 1'b0; cin_v = 1'b0; bad0 = 1'b0; bad3 = 1'b0;
    a_v = '0; b_v = '0;
    model_reset();
    idle(2);
    chk("rst.state", 32'(i3.state), 32'd0);
    rst = 1'b0;
    idle(1);

    // Single correct vector at LATENCY=0
    issue(16'h55DF, 16'h55DF, 1'b0, 1'b0, 1'b0);
    chk("t1.chk_valid", 32'(i0.chk_valid), 32'd1);
    chk("t1.mismatch", 32'(i0.mismatch), 32'd0);
    chk("t1.pass_cnt", 32'(i0.pass_cnt), 32'd1);
    idle(4);
    clear_tick();

    // Back-to-back issues
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    chk("t2.chk_valid_a", 32'(i0.chk_valid), 32'd1);
    issue(16'hFCDF, 16'h55DF, 1'b0, 1'b0, 1'b0);
    chk("t2.chk_valid_b", 32'(i0.chk_valid), 32'd1);
    chk("t2.pass_cnt", 32'(i0.pass_cnt), 32'd2);
    chk("t2.fail_cnt", 32'(i0.fail_cnt), 32'd0);
    idle(4);

    // Clear on the same cycle as a LATENCY=0 compare drops it
    clr = 1'b1;
    issue(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0);
    clr = 1'b0;
    chk("clr.drop", 32'(i0.chk_valid), 32'd0);
    idle(4);
    clear_tick();

    // Faulty result on the LATENCY=3 instance
    issue(16'hFCDF, 16'h55DF, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk("t3.early", 32'(i3.chk_valid), 32'd0);
    idle(1);
    chk("t3.chk_valid", 32'(i3.chk_valid), 32'd1);
    chk("t3.mismatch", 32'(i3.mismatch), 32'd1);
    chk("t3.err_sticky", 32'(i3.err_sticky), 32'd1);
    chk("t3.ff_exp", 32'(i3.first_fail_exp), 32'h152BE);
    chk("t3.ff_got", 32'(i3.first_fail_got), 32'h152BF);
    chk("t3.state", 32'(i3.state), 32'd2);

    // Correct vector after the failure
    issue(16'h0101, 16'h0202, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("t4.chk_valid", 32'(i3.chk_valid), HALT ? 32'd0 : 32'd1);
    chk("t4.pass_cnt", 32'(i3.pass_cnt), HALT ? 32'd0 : 32'd1);
    chk("t4.fail_cnt", 32'(i3.fail_cnt), 32'd1);
    chk("t4.ff_exp_held", 32'(i3.first_fail_exp), 32'h152BE);
    idle(2);

    // Asynchronous reset with three items in flight
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    issue(16'h3333, 16'h4444, 1'b1, 1'b0, 1'b0);
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst.async_state", 32'(i3.state), 32'd0);
    chk("rst.async_sticky", 32'(i3.err_sticky), 32'd0);
    chk("rst.async_fail", 32'(i3.fail_cnt), 32'd0);
    chk("rst.async_pass0", 32'(i0.pass_cnt), 32'd0);
    tick();
    rst = 1'b0;
    idle(6);

    // Saturation of the 4-bit fail counter
    clear_tick();
    for (int k = 0; k < 18; k++) issue(16'(k * 997), 16'(k * 131), 1'(k % 2), 1'b0, 1'b1);
    idle(4);
    chk("sat.fail_cnt", 32'(i3.fail_cnt), HALT ? 32'd1 : 32'hF);
    clear_tick();
    chk("sat.clr_fail", 32'(i3.fail_cnt), 32'd0);
    chk("sat.clr_pass", 32'(i3.pass_cnt), 32'd0);
    chk("sat.clr_sticky", 32'(i3.err_sticky), 32'd0);
    chk("sat.clr_state", 32'(i3.state), 32'd0);
    idle(4);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      iv    = ($urandom_range(0, 3) != 0);
      a_v   = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      b_v   = 16'($urandom);
      cin_v = 1'($urandom_range(0, 1));
      bad0  = ($urandom_range(0, 15) == 0);
      bad3  = ($urandom_range(0, 7) == 0);
      clr   = ($urandom_range(0, 39) == 0);
      tick();
    end
    iv = 1'b0; clr = 1'b0; bad0 = 1'b0; bad3 = 1'b0;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cla_result_checker.md
Name: cla_result_checker

Overview:
- Self-checking response monitor for the 16-bit CLA adder family.
- Sits at the output end of the adder interface: receives the operands that were issued to the adder and the adder's {Cout, Z}.
- Computes the golden sum, aligns it to the adder's latency, compares, counts passes and failures, and captures the first failure.
- Synthesizable, so it can run on-board next to the adder as well as in simulation.

Parameters:
WIDTH, 16, operand/sum width in bits
LATENCY, 0, cycles from operand issue to valid Z/Cout (0..8)
CNT_W, 16, width of the pass/fail counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous clear of counters, sticky flag and capture registers
in_valid  input  1  A/B/Cin are being issued to the adder this cycle
A  input  WIDTH  operand A as issued to the adder
B  input  WIDTH  operand B as issued to the adder
Cin  input  1  carry-in as issued to the adder
Z  input  WIDTH  adder sum output
Cout  input  1  adder carry output
chk_valid  output  1  one-cycle pulse: a comparison completed
mismatch  output  1  qualified by chk_valid: the last comparison failed
err_sticky  output  1  set on first mismatch, held until reset or clear
pass_cnt  output  CNT_W  number of passing comparisons, saturating
fail_cnt  output  CNT_W  number of failing comparisons, saturating
first_fail_exp  output  WIDTH+1  expected {Cout,Z} of the first failure
first_fail_got  output  WIDTH+1  observed {Cout,Z} of the first failure
state  output  2  00 IDLE, 01 ACTIVE, 10 FAILED

Behaviour:
- Reset (asynchronous, active-high) clears all outputs, counters, the pipeline valid bits and captures to 0; state = IDLE.
- Golden value: exp = A + B + Cin, computed at full WIDTH+1 width. Bit WIDTH is the expected Cout.
- Alignment:
  - exp and in_valid enter a LATENCY-deep shift pipeline.
  - The stage-LATENCY entry is compared against {Cout,Z} sampled in the same cycle.
  - LATENCY=0 compares in the in_valid cycle itself.
- Compare-result registers: chk_valid, mismatch, the counters and the captures all update on the clock edge after the compare cycle. Total observable delay is LATENCY+1 cycles from in_valid.
- Back-to-back in_valid every cycle is supported; each issue produces exactly one chk_valid.
- Counters: pass_cnt increments on a match, fail_cnt on a mismatch. Both saturate at all-ones and do not wrap.
- first_fail_exp and first_fail_got load only when err_sticky is 0 and a mismatch occurs.
- FSM:
  - IDLE -> ACTIVE on in_valid.
  - ACTIVE -> IDLE when the pipeline is empty and in_valid=0.
  - ACTIVE -> FAILED on mismatch.
  - FAILED holds until clear or reset, then goes to IDLE.
- clear:
  - Zeroes counters, sticky flag and captures, and forces IDLE.
  - Does not flush the pipeline: in-flight items are still compared after clear.
  - If clear coincides with a compare, clear wins and that compare result is dropped (no chk_valid).
- Reset mid-operation discards all in-flight items; no chk_valid follows.
- Z/Cout are ignored in cycles with no valid pipeline entry.

Optional Feature:
- Macro: CLA_CHK_HALT_EN.
- Defined:
  - After the first mismatch (state FAILED), further comparisons are suppressed: no chk_valid, and counters freeze.
  - Items keep draining from the pipeline.
- Undefined:
  - Checking continues in FAILED; chk_valid, mismatch and the counters keep updating.
  - Captures still hold the first failure only.

Test Plan:
- LATENCY=0, correct adder model; A=0x55DF, B=0x55DF, Cin=0 -> chk_valid one cycle later, exp 0x0ABBE, mismatch=0, pass_cnt=1.
- A=0xFFFF, B=0xFFFF, Cin=0, then A=0xFCDF, B=0x55DF, Cin=0 back-to-back -> two chk_valid pulses (exp 0x1FFFE, then 0x152BE); pass_cnt=2, fail_cnt=0.
- LATENCY=3, model forced to return Z=0x52BF for A=0xFCDF, B=0x55DF -> mismatch exactly 4 cycles after in_valid; err_sticky=1, first_fail_exp=0x152BE, first_fail_got=0x152BF, state=FAILED.
- After the failure, issue one correct vector -> without CLA_CHK_HALT_EN: pass_cnt increments; with CLA_CHK_HALT_EN: no chk_valid and counters unchanged.
- Assert reset for 1 cycle while 3 items are in flight (LATENCY=3) -> all outputs 0 immediately, no chk_valid afterwards, state=IDLE.
- Preload fail_cnt near saturation (CNT_W=4, 16 failing vectors) -> fail_cnt stops at 0xF; then clear -> counters 0, err_sticky=0, state=IDLE.
